prbs_checker: RTL and testbench

Serial PRBS receiver/checker that sits directly downstream of prbs_generator and consumes its bit stream. It self-synchronises a local LFSR to the incoming sequence, declares lock, and then free-runs the local LFSR. It counts received bits and bit errors, and drops lock on excessive error density. Used for loopback BER measurement of the PRBS path.

---
 rtl/prbs_pkg.sv | 26 ++
 rtl/prbs_lfsr_step.sv | 24 ++
 rtl/prbs_checker.sv | 153 +++++++++++++++
 tb/tb_prbs_checker.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: FSM state type and standard polynomial constants.
// No logic; constants only.
// Used by both the PRBS generator and checker so their polynomials always agree.
package prbs_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // PRBS7: x^7 + x^6 + 1
    localparam int PRBS7_ORDER  = 7;
    localparam int PRBS7_TAP_A  = 7;
    localparam int PRBS7_TAP_B  = 6;

    // PRBS15: x^15 + x^14 + 1
    localparam int PRBS15_ORDER = 15;
    localparam int PRBS15_TAP_A = 15;
    localparam int PRBS15_TAP_B = 14;

    // PRBS31: x^31 + x^28 + 1
    localparam int PRBS31_ORDER = 31;
    localparam int PRBS31_TAP_A = 31;
    localparam int PRBS31_TAP_B = 28;

endpackage

// File: rtl/prbs_lfsr_step.sv
// One LFSR step: predicted next bit and next shift-register contents.
// Purely combinational, zero latency.
// No flow control; the caller decides when to commit sr_next.
module prbs_lfsr_step #(
    parameter int ORDER = 7,
    parameter int TAP_A = 7,
    parameter int TAP_B = 6
) (
    input  logic [ORDER-1:0] sr,
    input  logic             in_bit,
    input  logic             load_in,
    output logic             pred,
    output logic [ORDER-1:0] sr_next
);

    // sr[0] is the newest bit; tap k refers to the bit received k steps ago.
    // load_in shifts in the received bit (self-seeding), otherwise the
    // prediction is shifted in so the register free-runs.
    always_comb begin
        pred    = sr[TAP_A-1] ^ sr[TAP_B-1];
        sr_next = {sr[ORDER-2:0], (load_in ? in_bit : pred)};
    end

endmodule

// File: rtl/prbs_checker.sv
// PRBS checker: self-syncs a local LFSR to the received stream, then counts bits/errors.
// Outputs registered: locked/err_pulse/counters reflect a valid bit one cycle after it.
// in_valid=0 stalls all state; no backpressure is applied upstream.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int ORDER       = PRBS7_ORDER,
    parameter int TAP_A       = PRBS7_TAP_A,
    parameter int TAP_B       = PRBS7_TAP_B,
    parameter int LOCK_THRESH = 16,
    parameter int WINDOW      = 64,
    parameter int LOSS_THRESH = 8,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             prbs_in,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);

    localparam int MW = $clog2(LOCK_THRESH + 1);
    localparam int WW = $clog2(WINDOW + 1);
    localparam int EW = $clog2(LOSS_THRESH + 1);

    state_t           state_q, state_d;
    logic [ORDER-1:0] sr_q, sr_d;
    logic [MW-1:0]    match_q, match_d;
    logic [WW-1:0]    win_bits_q, win_bits_d;
    logic [EW-1:0]    win_errs_q, win_errs_d;
    logic             locked_q, locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

    logic             pred;
    logic [ORDER-1:0] sr_step;
    logic             mismatch;
    logic             bit_inc;
    logic             err_inc;
    logic [EW-1:0]    win_errs_nxt;

    prbs_lfsr_step #(
        .ORDER (ORDER),
        .TAP_A (TAP_A),
        .TAP_B (TAP_B)
    ) u_step (
        .sr      (sr_q),
        .in_bit  (prbs_in),
        .load_in (state_q == SEARCH),
        .pred    (pred),
        .sr_next (sr_step)
    );

    // Lock FSM, LFSR advance, error-density window and saturating statistics.
    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        match_d      = match_q;
        win_bits_d   = win_bits_q;
        win_errs_d   = win_errs_q;
        err_pulse_d  = 1'b0;
        err_cnt_d    = err_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        bit_inc      = 1'b0;
        err_inc      = 1'b0;
        mismatch     = (prbs_in != pred);
        win_errs_nxt = win_errs_q + EW'(mismatch);

        if (in_valid) begin
            sr_d = sr_step;
            if (state_q == SEARCH) begin
                // An all-zero register predicts zero forever, so it never counts as a match.
                if ((sr_q != '0) && !mismatch) begin
                    if (match_q == MW'(LOCK_THRESH - 1)) begin
                        state_d    = LOCKED;
                        match_d    = '0;
                        win_bits_d = '0;
                        win_errs_d = '0;
                    end else begin
                        match_d = match_q + MW'(1);
                    end
                end else begin
                    match_d = '0;
                end
            end else begin
                bit_inc     = 1'b1;
                err_inc     = mismatch;
                err_pulse_d = mismatch;
                if (win_errs_nxt == EW'(LOSS_THRESH)) begin
                    // Too many errors in this window: resync, keeping sr as-is.
                    state_d    = SEARCH;
                    match_d    = '0;
                    win_bits_d = '0;
                    win_errs_d = '0;
                end else if (win_bits_q == WW'(WINDOW - 1)) begin
                    // Current bit closes the window.
                    win_bits_d = '0;
                    win_errs_d = '0;
                end else begin
                    win_bits_d = win_bits_q + WW'(1);
                    win_errs_d = win_errs_nxt;
                end
            end
        end

        // clear drops any same-cycle increment; err_pulse is unaffected.
        if (clear) begin
            err_cnt_d = '0;
            bit_cnt_d = '0;
        end else begin
            if (bit_inc && (bit_cnt_q != '1)) bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (err_inc && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
        end

        locked_d = (state_d == LOCKED);
    end

    // State registers; synchronous reset overrides clear and all updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SEARCH;
            sr_q        <= '0;
            match_q     <= '0;
            win_bits_q  <= '0;
            win_errs_q  <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            bit_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            match_q     <= match_d;
            win_bits_q  <= win_bits_d;
            win_errs_q  <= win_errs_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_cnt_q;
    assign bit_count = bit_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: directed phase table plus randomized run against a history-based model.
// Two instances share stimulus: full-width counters and a 4-bit build for saturation.
// Outputs are sampled 1 time unit after each rising edge.
module tb_prbs_checker;

    localparam int ORDER       = 7;
    localparam int TAP_A       = 7;
    localparam int TAP_B       = 6;
    localparam int LOCK_THRESH = 16;
    localparam int WINDOW      = 64;
    localparam int LOSS_THRESH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        prbs_in = 1'b0;
    logic        locked, err_pulse, locked4, err_pulse4;
    logic [31:0] err_count, bit_count;
    logic [3:0]  err_count4, bit_count4;

    always #5 clk = ~clk;

    prbs_checker #(.CNT_W(32)) u_dut (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .prbs_in(prbs_in),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .bit_count(bit_count)
    );

    prbs_checker #(.CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .prbs_in(prbs_in),
        .locked(locked4), .err_pulse(err_pulse4), .err_count(err_count4), .bit_count(bit_count4)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic longint sat(input longint x, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (x > mx) ? mx : x;
    endfunction

    // Reference generator: PRBS7 stream x^7+x^6+1 from seed 7'h7F.
    logic [6:0] g_sr;

    // Behavioural model: a queue of the last ORDER bits of the checker's notion of
    // the stream (oldest first). Prediction follows b[n] = b[n-TAP_A] ^ b[n-TAP_B].
    bit     hist[$];
    bit     m_locked, m_pulse;
    int     m_match, m_wb, m_we;
    longint m_err, m_bits;

    task automatic model_step(input bit rst, input bit clr, input bit v, input bit b);
        bit p, nz, e;
        if (rst) begin
            m_locked = 0; m_pulse = 0; m_match = 0; m_wb = 0; m_we = 0;
            m_err = 0; m_bits = 0;
            hist.delete();
            repeat (ORDER) hist.push_back(1'b0);
            return;
        end
        m_pulse = 0;
        if (v) begin
            p  = hist[ORDER-TAP_A] ^ hist[ORDER-TAP_B];
            nz = 0;
            foreach (hist[i]) nz |= hist[i];
            void'(hist.pop_front());
            if (!m_locked) begin
                hist.push_back(b);
                if (nz && (b == p)) begin
                    m_match++;
                    if (m_match == LOCK_THRESH) begin
                        m_locked = 1; m_match = 0; m_wb = 0; m_we = 0;
                    end
                end else begin
                    m_match = 0;
                end
            end else begin
                hist.push_back(p);
                e = (b != p);
                m_pulse = e;
                m_bits++;
                m_wb++;
                if (e) begin m_err++; m_we++; end
                if (m_we == LOSS_THRESH) begin
                    m_locked = 0; m_match = 0; m_wb = 0; m_we = 0;
                end else if (m_wb == WINDOW) begin
                    m_wb = 0; m_we = 0;
                end
            end
        end
        if (clr) begin m_err = 0; m_bits = 0; end
    endtask

    // One clock: pick the bit, drive inputs, advance model, compare every output.
    task automatic drive(input bit rst, input bit clr, input bit vld, input bit flip,
                         input bit zeros, input bit reseed);
        bit b;
        if (reseed) g_sr = 7'h7F;
        if (vld) begin
            if (zeros) b = 1'b0;
            else begin
                b    = g_sr[TAP_A-1] ^ g_sr[TAP_B-1];
                g_sr = {g_sr[5:0], b};
                b    = b ^ flip;
            end
        end else begin
            b = 1'($urandom_range(0, 1));
        end
        reset = rst; clear = clr; in_valid = vld; prbs_in = b;
        @(posedge clk);
        model_step(rst, clr, vld, b);
        #1;
        check("locked",     longint'(locked),     longint'(m_locked));
        check("err_pulse",  longint'(err_pulse),  longint'(m_pulse));
        check("err_count",  longint'(err_count),  sat(m_err, 32));
        check("bit_count",  longint'(bit_count),  sat(m_bits, 32));
        check("locked4",    longint'(locked4),    longint'(m_locked));
        check("err_count4", longint'(err_count4), sat(m_err, 4));
        check("bit_count4", longint'(bit_count4), sat(m_bits, 4));
    endtask

    typedef struct {
        string nm;
        bit    rst;
        bit    seed;
        bit    clr;
        bit    vld;
        int    mode;     // 0 clean, 1 flipped bits, 2 all zeros
        int    cycles;
        bit    e_locked;
        bit    e_pulse;
        int    e_err;
        int    e_bits;
    } phase_t;

    phase_t tbl[14];

    initial begin
        g_sr = 7'h7F;
        tbl[0]  = '{"reset",         1, 1, 0, 0, 0,   3, 0, 0, 0,   0};
        tbl[1]  = '{"pre_lock22",    0, 0, 0, 1, 0,  22, 0, 0, 0,   0};
        tbl[2]  = '{"lock_at23",     0, 0, 0, 1, 0,   1, 1, 0, 0,   0};
        tbl[3]  = '{"clean127",      0, 0, 0, 1, 0, 127, 1, 0, 0, 127};
        tbl[4]  = '{"single_flip",   0, 0, 0, 1, 1,   1, 1, 1, 1, 128};
        tbl[5]  = '{"after_flip",    0, 0, 0, 1, 0,   1, 1, 0, 1, 129};
        tbl[6]  = '{"clear_idle",    0, 0, 1, 0, 0,   1, 1, 0, 0,   0};
        tbl[7]  = '{"burst8_loss",   0, 0, 0, 1, 1,   8, 0, 1, 8,   8};
        tbl[8]  = '{"relock15",      0, 0, 0, 1, 0,  15, 0, 0, 8,   8};
        tbl[9]  = '{"relock16",      0, 0, 0, 1, 0,   1, 1, 0, 8,   8};
        tbl[10] = '{"continue5",     0, 0, 0, 1, 0,   5, 1, 0, 8,  13};
        tbl[11] = '{"clear_w_err",   0, 0, 1, 1, 1,   1, 1, 1, 0,   0};
        tbl[12] = '{"reset_locked",  1, 1, 0, 0, 0,   1, 0, 0, 0,   0};
        tbl[13] = '{"zeros200",      0, 0, 0, 1, 2, 200, 0, 0, 0,   0};

        foreach (tbl[k]) begin
            for (int c = 0; c < tbl[k].cycles; c++)
                drive(tbl[k].rst, tbl[k].clr, tbl[k].vld, tbl[k].mode == 1,
                      tbl[k].mode == 2, tbl[k].seed && (c == 0));
            check({tbl[k].nm, ".locked"},    longint'(locked),     longint'(tbl[k].e_locked));
            check({tbl[k].nm, ".err_pulse"}, longint'(err_pulse),  longint'(tbl[k].e_pulse));
            check({tbl[k].nm, ".err_count"}, longint'(err_count),  longint'(tbl[k].e_err));
            check({tbl[k].nm, ".bit_count"}, longint'(bit_count),  longint'(tbl[k].e_bits));
            check({tbl[k].nm, ".bits4"},     longint'(bit_count4), sat(tbl[k].e_bits, 4));
        end

        // Gapped stream: 50% in_valid, sparse flips, an error burst each
        // thousand cycles, rare clears and one mid-run reset.
        drive(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            bit rst_i, clr_i, vld_i, flp_i;
            rst_i = (i == 1500);
            vld_i = 1'($urandom_range(0, 1));
            clr_i = ($urandom_range(0, 699) == 0);
            if ((i % 1000) >= 600 && (i % 1000) < 640) flp_i = 1'($urandom_range(0, 1));
            else                                       flp_i = ($urandom_range(0, 63) == 0);
            drive(rst_i, clr_i, vld_i, flp_i, 0, rst_i);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
